// File: rtl/grc_word_packer_pkg.sv
// Shared types and elaboration helpers for the word packer capture stage.
// Sizes the lane and idle counters and names the packer's two control states.
package grc_tb_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    FLUSH = 1'b1
  } pack_state_t;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  function automatic int pack_ratio(input int num_bytes, input int in_width);
    return (num_bytes * 8) / in_width;
  endfunction

endpackage

// File: rtl/grc_word_packer.sv
// Packs narrow AXI-Stream samples into NUM_BYTES-wide words for the word file writer,
// flushing partial words on tlast or after an idle timeout, with transfer counters.
module grc_word_packer
  import grc_tb_pkg::*;
#(
  parameter bit                  LISTEN_ONLY = 1'b0,
  parameter int                  IN_WIDTH    = 16,
  parameter int                  NUM_BYTES   = 4,
  parameter int                  FLUSH_IDLE  = 64,
  parameter logic [IN_WIDTH-1:0] PAD         = '0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic [IN_WIDTH-1:0]    s_tdata,
  input  logic                   s_tvalid,
  input  logic                   s_tlast,
  output logic                   s_tready,
  output logic                   valid,
  output logic [NUM_BYTES*8-1:0] word,
  output logic                   wr_file,
  input  logic                   rdy_i,
  output logic [31:0]            word_count,
  output logic [15:0]            pkt_count,
  output logic                   overflow
);

  localparam int W      = NUM_BYTES * 8;
  localparam int RATIO  = pack_ratio(NUM_BYTES, IN_WIDTH);
  localparam int LANE_W = (clog2(RATIO) > 0) ? clog2(RATIO) : 1;
  localparam int IDLE_W = (clog2(FLUSH_IDLE + 1) > 0) ? clog2(FLUSH_IDLE + 1) : 1;

  localparam logic [LANE_W-1:0] LAST_LANE  = LANE_W'(RATIO - 1);
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'((FLUSH_IDLE > 0) ? FLUSH_IDLE - 1 : 0);
  localparam logic [W-1:0]      PAD_WORD   = {RATIO{PAD}};

  pack_state_t       state;
  pack_state_t       state_next;
  logic [LANE_W-1:0] lane;
  logic [W-1:0]      acc;
  logic [IDLE_W-1:0] idle_cnt;
  logic [W-1:0]      out_word;
  logic              out_valid;
  logic              out_wr_file;
  logic              out_pkt;
  logic [31:0]       word_cnt;
  logic [15:0]       pkt_cnt;
  logic              ovf;
  logic              ready_en;

  logic [W-1:0]      merged;
  logic              slot_free;
  logic              ready_c;
  logic              accept;
  logic              complete;
  logic              timeout_hit;
  logic              flush_now;
  logic              transfer;
  logic              load;

  // The accumulator keeps PAD in every lane not yet written, so a completing sample
  // only has to overwrite its own lane to form the finished word.
  always_comb begin
    merged = acc;
    for (int k = 0; k < RATIO; k++) begin
      if (lane == LANE_W'(k)) begin
        merged[W-1-k*IN_WIDTH -: IN_WIDTH] = s_tdata;
      end
    end
  end

  // The timeout is judged from the count alone, so in passive mode it can land on
  // the same edge as a completing sample and is then reported as a dropped flush.
  always_comb begin
    state_next  = state;
    flush_now   = 1'b0;
    slot_free   = LISTEN_ONLY || !out_valid || rdy_i;
    ready_c     = ready_en && enable && (state == FILL) && slot_free;
    accept      = s_tvalid && ready_c;
    complete    = accept && ((lane == LAST_LANE) || s_tlast);
    timeout_hit = (FLUSH_IDLE != 0) && enable && (lane != '0) && (idle_cnt == IDLE_LIMIT);
    transfer    = enable && out_valid && (LISTEN_ONLY || rdy_i);

    case (state)
      FILL: begin
        if (timeout_hit && !accept) begin
          if (slot_free) begin
            flush_now = 1'b1;
          end else begin
            state_next = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (enable && slot_free) begin
          flush_now  = 1'b1;
          state_next = FILL;
        end
      end
      default: begin
        state_next = FILL;
      end
    endcase

    load = complete || flush_now;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= FILL;
    end else if (enable) begin
      state <= state_next;
    end
  end

  // Packing lanes, idle timer, output slot and counters; everything holds while disabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lane        <= '0;
      acc         <= PAD_WORD;
      idle_cnt    <= '0;
      out_word    <= '0;
      out_valid   <= 1'b0;
      out_wr_file <= 1'b0;
      out_pkt     <= 1'b0;
      word_cnt    <= '0;
      pkt_cnt     <= '0;
      ovf         <= 1'b0;
      ready_en    <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (enable) begin
        if (load) begin
          lane <= '0;
          acc  <= PAD_WORD;
        end else if (accept) begin
          lane <= lane + LANE_W'(1);
          acc  <= merged;
        end

        if (accept || load || (lane == '0)) begin
          idle_cnt <= '0;
        end else if (!timeout_hit) begin
          idle_cnt <= idle_cnt + IDLE_W'(1);
        end

        if (load) begin
          out_word    <= complete ? merged : acc;
          out_wr_file <= complete ? s_tlast : 1'b1;
          out_pkt     <= complete && s_tlast;
          out_valid   <= 1'b1;
        end else if (transfer) begin
          out_valid   <= 1'b0;
        end

        word_cnt <= word_cnt + 32'(transfer);
        pkt_cnt  <= pkt_cnt + 16'(transfer && out_pkt);

        if (LISTEN_ONLY && complete && timeout_hit) begin
          ovf <= 1'b1;
        end
      end
    end
  end

  assign s_tready   = ready_c;
  assign valid      = out_valid;
  assign word       = out_word;
  assign wr_file    = out_wr_file;
  assign word_count = word_cnt;
  assign pkt_count  = pkt_cnt;
  assign overflow   = ovf;

endmodule
